// File: rtl/jellyvl_synctimer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jellyvl_synctimer_pkg
//  Purpose  : Shared types, adjust-sign encoding and step derivation for the
//             synchronised local timer and its adjuster driver.
//  Revision : 1.0  initial release
// ============================================================================
package jellyvl_synctimer_pkg;

  localparam int DEFAULT_TIMER_WIDTH = 64;

  typedef logic [DEFAULT_TIMER_WIDTH-1:0] t_time;

  // Adjust sign encoding used on the adjust handshake
  localparam logic ADJUST_SIGN_PLUS  = 1'b0;
  localparam logic ADJUST_SIGN_MINUS = 1'b1;

  typedef struct packed {
    logic [31:0] step_int;
    logic [31:0] step_frac;
  } t_step;

  // Split NUM/DEN into an integer part and a fractional remainder
  function automatic t_step calc_step(input int num, input int den);
    t_step s;
    if (den < 1) begin
      s.step_int  = '0;
      s.step_frac = '0;
    end else begin
      s.step_int  = 32'(num / den);
      s.step_frac = 32'(num % den);
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jellyvl_synctimer_frac_step.sv
`default_nettype none
// ============================================================================
//  Module   : jellyvl_synctimer_frac_step
//  Purpose  : Fractional accumulator producing the per-cycle integer step
//             (STEP_INT plus a carry whenever the remainder overflows).
//  Revision : 1.0  initial release
// ============================================================================
module jellyvl_synctimer_frac_step
  import jellyvl_synctimer_pkg::*;
#(
  parameter int TIMER_WIDTH = 64,
  parameter int NUMERATOR   = 10,
  parameter int DENOMINATOR = 3,
  parameter int FRAC_WIDTH  = $clog2(DENOMINATOR) + 1
) (
  input  logic                   rst,
  input  logic                   clk,
  input  logic                   clear,
  output logic [TIMER_WIDTH-1:0] step
);

  localparam t_step STEP      = calc_step(NUMERATOR, DENOMINATOR);
  localparam int    SUM_WIDTH = FRAC_WIDTH + 1;

  localparam logic [SUM_WIDTH-1:0]   C_STEP_FRAC = SUM_WIDTH'(STEP.step_frac);
  localparam logic [SUM_WIDTH-1:0]   C_DEN       = SUM_WIDTH'(DENOMINATOR);
  localparam logic [TIMER_WIDTH-1:0] C_STEP_INT  = TIMER_WIDTH'(STEP.step_int);

  logic [FRAC_WIDTH-1:0] frac_q;
  logic [FRAC_WIDTH-1:0] frac_d;
  logic [SUM_WIDTH-1:0]  sum;
  logic                  carry;

  // Remainder accumulation with carry-out; a clear restarts the phase at zero
  always_comb begin
    sum   = {1'b0, frac_q} + C_STEP_FRAC;
    carry = 1'b0;
    if (sum >= C_DEN) begin
      carry  = 1'b1;
      frac_d = FRAC_WIDTH'(sum - C_DEN);
    end else begin
      frac_d = sum[FRAC_WIDTH-1:0];
    end
    if (clear) begin
      frac_d = '0;
    end
  end

  // Integer step for this cycle, zero-extended to timer width
  always_comb begin
    step = C_STEP_INT + TIMER_WIDTH'(carry);
  end

  // Remainder register
  always_ff @(posedge clk) begin
    if (rst) begin
      frac_q <= '0;
    end else begin
      frac_q <= frac_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/jellyvl_synctimer_timer.sv
`default_nettype none
// ============================================================================
//  Module   : jellyvl_synctimer_timer
//  Purpose  : Local synchronised timer advancing NUMERATOR/DENOMINATOR units
//             per clock, with +/-1 unit adjust handshake and hard time load.
//  Revision : 1.0  initial release
// ============================================================================
module jellyvl_synctimer_timer
  import jellyvl_synctimer_pkg::*;
#(
  parameter int                     TIMER_WIDTH = 64,
  parameter int                     NUMERATOR   = 10,
  parameter int                     DENOMINATOR = 3,
  parameter int                     FRAC_WIDTH  = $clog2(DENOMINATOR) + 1,
  parameter logic [TIMER_WIDTH-1:0] INIT_TIME   = '0
) (
  input  logic                   rst,
  input  logic                   clk,
  input  logic [TIMER_WIDTH-1:0] set_time,
  input  logic                   set_valid,
  input  logic                   adjust_sign,
  input  logic                   adjust_valid,
  output logic                   adjust_ready,
  output logic [TIMER_WIDTH-1:0] current_time
);

  // A step of at least one unit keeps the timer monotonic under a minus adjust
  if (DENOMINATOR < 1 || NUMERATOR < DENOMINATOR) begin : g_param_check
    $error("jellyvl_synctimer_timer: require DENOMINATOR >= 1 and NUMERATOR >= DENOMINATOR");
  end

  localparam logic [TIMER_WIDTH-1:0] C_ONE = TIMER_WIDTH'(1);

  logic                   enable_q;
  logic [TIMER_WIDTH-1:0] time_q;
  logic [TIMER_WIDTH-1:0] time_d;
  logic [TIMER_WIDTH-1:0] step;
  logic                   accept;

  jellyvl_synctimer_frac_step #(
    .TIMER_WIDTH (TIMER_WIDTH),
    .NUMERATOR   (NUMERATOR),
    .DENOMINATOR (DENOMINATOR),
    .FRAC_WIDTH  (FRAC_WIDTH)
  ) u_frac_step (
    .rst   (rst),
    .clk   (clk),
    .clear (set_valid),
    .step  (step)
  );

  // Adjust is refused for one cycle after reset and whenever a load is present
  always_comb begin
    adjust_ready = enable_q & ~set_valid;
    accept       = adjust_valid & adjust_ready;
  end

  // Next time: load wins, then an accepted adjust, otherwise the plain step
  always_comb begin
    if (set_valid) begin
      time_d = set_time;
    end else if (accept) begin
      if (adjust_sign == ADJUST_SIGN_PLUS) begin
        time_d = time_q + step + C_ONE;
      end else begin
        time_d = time_q + step - C_ONE;
      end
    end else begin
      time_d = time_q + step;
    end
  end

  // Timer and handshake-enable registers
  always_ff @(posedge clk) begin
    if (rst) begin
      time_q   <= INIT_TIME;
      enable_q <= 1'b0;
    end else begin
      time_q   <= time_d;
      enable_q <= 1'b1;
    end
  end

  assign current_time = time_q;

endmodule
`default_nettype wire

// File: tb/tb_jellyvl_synctimer_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jellyvl_synctimer_timer
//  Purpose  : Self-checking bench for jellyvl_synctimer_timer using three
//             configurations (10/3 64-bit, 4/4 8-bit wrap, 1/1 64-bit).
//  Revision : 1.0  initial release
// ============================================================================
module tb_jellyvl_synctimer_timer;
  import jellyvl_synctimer_pkg::*;

  logic clk;
  logic rst;

  // Instance A: 64-bit, 10/3, INIT 0
  logic  set_a, av_a, as_a, rdy_a;
  t_time st_a, cur_a;
  // Instance B: 8-bit, 4/4, INIT 250
  logic       set_b, av_b, as_b, rdy_b;
  logic [7:0] st_b, cur_b;
  // Instance C: 64-bit, 1/1, INIT 0
  logic  set_c, av_c, as_c, rdy_c;
  t_time st_c, cur_c;

  int checks = 0;
  int errors = 0;

  jellyvl_synctimer_timer #(
    .TIMER_WIDTH(64), .NUMERATOR(10), .DENOMINATOR(3), .INIT_TIME(64'd0)
  ) u_dut_a (
    .rst(rst), .clk(clk), .set_time(st_a), .set_valid(set_a),
    .adjust_sign(as_a), .adjust_valid(av_a), .adjust_ready(rdy_a),
    .current_time(cur_a)
  );

  jellyvl_synctimer_timer #(
    .TIMER_WIDTH(8), .NUMERATOR(4), .DENOMINATOR(4), .INIT_TIME(8'd250)
  ) u_dut_b (
    .rst(rst), .clk(clk), .set_time(st_b), .set_valid(set_b),
    .adjust_sign(as_b), .adjust_valid(av_b), .adjust_ready(rdy_b),
    .current_time(cur_b)
  );

  jellyvl_synctimer_timer #(
    .TIMER_WIDTH(64), .NUMERATOR(1), .DENOMINATOR(1), .INIT_TIME(64'd0)
  ) u_dut_c (
    .rst(rst), .clk(clk), .set_time(st_c), .set_valid(set_c),
    .adjust_sign(as_c), .adjust_valid(av_c), .adjust_ready(rdy_c),
    .current_time(cur_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------
  // Behavioural model: time = base + floor(n*NUM/DEN) + net adjusts,
  // where n counts stepping cycles since the last reset or load.
  // ---------------------------------------------------------------------
  longint      m_num  [3] = '{10, 4, 1};
  longint      m_den  [3] = '{3, 4, 1};
  logic [63:0] m_mask [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_00FF,
                              64'hFFFF_FFFF_FFFF_FFFF};
  logic [63:0] m_base [3];
  longint      m_n    [3];
  longint      m_adj  [3];
  bit          m_en   [3];
  bit          started = 1'b0;

  task automatic mstep(input int i, input bit r, input bit s, input logic [63:0] st,
                       input bit v, input bit sg, input logic [63:0] init);
    bit rdy;
    if (r) begin
      m_base[i] = init;
      m_n[i]    = 0;
      m_adj[i]  = 0;
      m_en[i]   = 1'b0;
    end else begin
      rdy = m_en[i] & ~s;
      if (s) begin
        m_base[i] = st;
        m_n[i]    = 0;
        m_adj[i]  = 0;
      end else begin
        m_n[i] = m_n[i] + 1;
        if (v && rdy) m_adj[i] = m_adj[i] + (sg ? -1 : 1);
      end
      m_en[i] = 1'b1;
    end
  endtask

  function automatic logic [63:0] exp_time(input int i);
    logic [63:0] v;
    v = m_base[i] + 64'((m_n[i] * m_num[i]) / m_den[i]) + 64'(m_adj[i]);
    return v & m_mask[i];
  endfunction

  always @(posedge clk) begin
    mstep(0, rst, set_a, st_a, av_a, as_a, 64'd0);
    mstep(1, rst, set_b, {56'd0, st_b}, av_b, as_b, 64'd250);
    mstep(2, rst, set_c, st_c, av_c, as_c, 64'd0);
    started = 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of all instances against the model
  always @(negedge clk) begin
    if (started) begin
      chk("model_time_a", cur_a, exp_time(0));
      chk("model_time_b", {56'd0, cur_b}, exp_time(1));
      chk("model_time_c", cur_c, exp_time(2));
      if (!rst) begin
        chk("model_ready_a", {63'd0, rdy_a}, {63'd0, m_en[0] & ~set_a});
        chk("model_ready_b", {63'd0, rdy_b}, {63'd0, m_en[1] & ~set_b});
        chk("model_ready_c", {63'd0, rdy_c}, {63'd0, m_en[2] & ~set_c});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------
  // Directed stimulus with hand-computed expectations
  // ---------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    set_a = 1'b0; st_a = '0; av_a = 1'b0; as_a = ADJUST_SIGN_PLUS;
    set_b = 1'b0; st_b = '0; av_b = 1'b0; as_b = ADJUST_SIGN_PLUS;
    set_c = 1'b0; st_c = '0; av_c = 1'b0; as_c = ADJUST_SIGN_PLUS;

    tick(2);
    chk("reset_a", cur_a, 64'd0);
    chk("reset_b", {56'd0, cur_b}, 64'd250);
    rst  = 1'b0;
    // C: hold a minus request from release onward
    av_c = 1'b1; as_c = ADJUST_SIGN_MINUS;
    #1;
    chk("ready_first_cycle_a", {63'd0, rdy_a}, 64'd0);

    tick(5);
    chk("wrap_b_255", {56'd0, cur_b}, 64'd255);
    chk("minus_hold_c", cur_c, 64'd1);
    av_b = 1'b1; as_b = ADJUST_SIGN_PLUS;
    tick(1);
    chk("wrap_b_adjust", {56'd0, cur_b}, 64'd1);
    av_b = 1'b0;

    tick(24);
    chk("nominal_30_a", cur_a, 64'd100);
    chk("minus_hold30_c", cur_c, 64'd1);
    av_c = 1'b0;

    tick(270);
    chk("nominal_300_a", cur_a, 64'd1000);
    chk("resume_c", cur_c, 64'd271);

    // Five accepted plus adjusts: floor(3050/3) + 5
    av_a = 1'b1; as_a = ADJUST_SIGN_PLUS;
    #1;
    chk("ready_plus_a", {63'd0, rdy_a}, 64'd1);
    tick(5);
    chk("plus5_a", cur_a, 64'd1021);

    // Three minus adjusts: floor(3080/3) + 5 - 3
    as_a = ADJUST_SIGN_MINUS;
    tick(3);
    chk("minus3_a", cur_a, 64'd1028);

    // Load colliding with an adjust request
    set_a = 1'b1; st_a = 64'h1000; as_a = ADJUST_SIGN_PLUS;
    #1;
    chk("collide_ready_a", {63'd0, rdy_a}, 64'd0);
    tick(1);
    set_a = 1'b0; av_a = 1'b0;
    chk("load_a", cur_a, 64'h1000);
    tick(1);
    chk("after_load1_a", cur_a, 64'h1003);
    tick(1);
    chk("after_load2_a", cur_a, 64'h1006);
    tick(1);
    chk("after_load3_a", cur_a, 64'h100A);

    // Load held as a level: timer frozen, ready low
    set_a = 1'b1; st_a = 64'h2000; av_a = 1'b1;
    tick(3);
    chk("held_load_a", cur_a, 64'h2000);
    chk("held_ready_a", {63'd0, rdy_a}, 64'd0);
    set_a = 1'b0;

    // Run with a plus request held, then reset mid-stream
    tick(20);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    #1;
    chk("midrst_time_a", cur_a, 64'd0);
    chk("midrst_ready_a", {63'd0, rdy_a}, 64'd0);
    tick(1);
    chk("midrst_step_a", cur_a, 64'd3);
    chk("midrst_ready2_a", {63'd0, rdy_a}, 64'd1);
    tick(1);
    chk("midrst_adj_a", cur_a, 64'd7);
    av_a = 1'b0;

    tick(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
